// File: rtl/seg_text_scroller.sv
`default_nettype none
// ============================================================================
// Module      : seg_text_scroller
// Description : Message buffer and right-to-left scroller that feeds two ASCII
//               character codes to the 7-segment character encoders.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_text_scroller #(
  parameter int MSG_DEPTH   = 16,
  parameter int STEP_CYCLES = 12500000
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Wr_DV,
  input  logic [7:0]                     i_Wr_Byte,
  input  logic                           i_Clear,
  input  logic                           i_Start,
  input  logic                           i_Stop,
  input  logic                           i_Loop,
  output logic [7:0]                     o_Char_Left,
  output logic [7:0]                     o_Char_Right,
  output logic                           o_Char_DV,
  output logic                           o_Busy,
  output logic                           o_Full,
  output logic [$clog2(MSG_DEPTH+1)-1:0] o_Len
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [LW-1:0] c_DEPTH     = LW'(MSG_DEPTH);
  localparam logic [TW-1:0] c_LAST_TICK = TW'(STEP_CYCLES - 1);
  localparam logic [7:0]    c_BLANK     = 8'h20;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SCROLL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] frame_q, frame_d;
  logic [LW-1:0] frame_nxt;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    left_q, left_d;
  logic [7:0]    right_q, right_d;
  logic          dv_q, dv_d;
  logic          full_q;
  logic          wr_en;
  logic [7:0]    nxt_left, nxt_right;
  logic [7:0]    msg_q [MSG_DEPTH];

  // Index of the frame that follows the current one; a fresh scroll or a wrap starts at 0.
  always_comb begin
    frame_nxt = frame_q + LW'(1);
    if (state_q == ST_IDLE || frame_q == len_q) begin
      frame_nxt = '0;
    end
  end

  // Character pair for frame_nxt: text enters on the right and leaves on the left.
  always_comb begin
    nxt_left  = c_BLANK;
    nxt_right = c_BLANK;
    if (frame_nxt != '0) begin
      nxt_left = msg_q[AW'(frame_nxt - LW'(1))];
    end
    if (frame_nxt < len_q) begin
      nxt_right = msg_q[AW'(frame_nxt)];
    end
  end

  // Next-state logic: buffer management in IDLE, step timing and frame sequencing in SCROLL.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    frame_d = frame_q;
    timer_d = timer_q;
    left_d  = left_q;
    right_d = right_q;
    dv_d    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Clear) begin
          len_d = '0;
        end else if (i_Start && len_q != '0) begin
          state_d = ST_SCROLL;
          frame_d = '0;
          timer_d = '0;
          left_d  = nxt_left;
          right_d = nxt_right;
          dv_d    = 1'b1;
        end else if (i_Wr_DV && len_q != c_DEPTH) begin
          wr_en = 1'b1;
          len_d = len_q + LW'(1);
        end
      end
      ST_SCROLL: begin
        if (i_Stop) begin
          state_d = ST_IDLE;
          frame_d = '0;
          timer_d = '0;
          left_d  = c_BLANK;
          right_d = c_BLANK;
          dv_d    = 1'b1;
        end else if (timer_q == c_LAST_TICK) begin
          timer_d = '0;
          dv_d    = 1'b1;
          if (frame_q != len_q || i_Loop) begin
            frame_d = frame_nxt;
            left_d  = nxt_left;
            right_d = nxt_right;
          end else begin
            // Last frame held its full step with looping off: blank and go idle.
            state_d = ST_IDLE;
            frame_d = '0;
            left_d  = c_BLANK;
            right_d = c_BLANK;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; the message storage itself is never reset.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      frame_q <= '0;
      timer_q <= '0;
      left_q  <= c_BLANK;
      right_q <= c_BLANK;
      dv_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      frame_q <= frame_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      right_q <= right_d;
      dv_q    <= dv_d;
      full_q  <= (len_d == c_DEPTH);
    end
  end

  // Message buffer append; only reachable from IDLE so the text is frozen while scrolling.
  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      msg_q[len_q[AW-1:0]] <= i_Wr_Byte;
    end
  end

  assign o_Char_Left  = left_q;
  assign o_Char_Right = right_q;
  assign o_Char_DV    = dv_q;
  assign o_Busy       = (state_q == ST_SCROLL);
  assign o_Full       = full_q;
  assign o_Len        = len_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_text_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_text_scroller
// Description : Self-checking bench for seg_text_scroller; frame pulses are
//               matched against a scoreboard of expected (cycle, left, right).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_text_scroller;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_dv = 1'b0;
  logic [7:0]    wr_byte = 8'h00;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [7:0]    ch_l, ch_r;
  logic          ch_dv, busy, full;
  logic [LW-1:0] len;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] l;
    logic [7:0] r;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic       clr;
    logic       st;
    logic       wr;
    logic [7:0] b;
    int         len;
    logic       full;
    logic       busy;
  } vec_t;
  vec_t vt[7];

  logic [7:0] model[$];

  seg_text_scroller #(.MSG_DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .i_Clear(clr), .i_Start(start), .i_Stop(stop), .i_Loop(loop_en),
    .o_Char_Left(ch_l), .o_Char_Right(ch_r), .o_Char_DV(ch_dv),
    .o_Busy(busy), .o_Full(full), .o_Len(len)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every DV pulse must match the oldest expected frame, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ch_dv) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL dv_unexpected cyc=%0d got %h/%h, required no pulse", cyc, ch_l, ch_r);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || e.l != ch_l || e.r != ch_r) begin
          fails++;
          $display("FAIL frame got cyc=%0d %h/%h, required cyc=%0d %h/%h",
                   cyc, ch_l, ch_r, e.cyc, e.l, e.r);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] m_left(input int k);
    return (k == 0) ? 8'h20 : model[k-1];
  endfunction

  function automatic logic [7:0] m_right(input int k);
    return (k < model.size()) ? model[k] : 8'h20;
  endfunction

  task automatic push_frame(input int c, input int k);
    exp_t e;
    e.cyc = c; e.l = m_left(k); e.r = m_right(k);
    sbq.push_back(e);
  endtask

  task automatic push_blank(input int c);
    exp_t e;
    e.cyc = c; e.l = 8'h20; e.r = 8'h20;
    sbq.push_back(e);
  endtask

  // Full non-looping scroll starting with i_Start driven during cycle s.
  task automatic push_scroll(input int s);
    for (int k = 0; k <= model.size(); k++) push_frame(s + 1 + k * STEP, k);
    push_blank(s + 1 + (model.size() + 1) * STEP);
  endtask

  task automatic write_str(input string str);
    for (int i = 0; i < str.len(); i++) begin
      wr_dv = 1'b1; wr_byte = str[i];
      if (model.size() < DEPTH) model.push_back(str[i]);
      @(negedge clk);
    end
    wr_dv = 1'b0;
  endtask

  initial begin
    int s;
    vt[0] = '{clr:1'b0, st:1'b0, wr:1'b1, b:"X", len:1, full:1'b0, busy:1'b0};
    vt[1] = '{clr:1'b1, st:1'b0, wr:1'b0, b:"Y", len:0, full:1'b0, busy:1'b0};
    vt[2] = '{clr:1'b1, st:1'b0, wr:1'b1, b:"Q", len:0, full:1'b0, busy:1'b0};
    vt[3] = '{clr:1'b0, st:1'b1, wr:1'b0, b:"R", len:0, full:1'b0, busy:1'b0};
    vt[4] = '{clr:1'b0, st:1'b0, wr:1'b1, b:"H", len:1, full:1'b0, busy:1'b0};
    vt[5] = '{clr:1'b0, st:1'b0, wr:1'b1, b:"I", len:2, full:1'b0, busy:1'b0};
    vt[6] = '{clr:1'b0, st:1'b0, wr:1'b0, b:"Z", len:2, full:1'b0, busy:1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_left", ch_l, 8'h20);
    chk("rst_right", ch_r, 8'h20);
    chk("rst_dv", ch_dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_len", len, 0);

    // IDLE command table
    for (int i = 0; i < 7; i++) begin
      clr = vt[i].clr; start = vt[i].st; wr_dv = vt[i].wr; wr_byte = vt[i].b;
      if (vt[i].clr) model.delete();
      else if (vt[i].st && model.size() > 0) begin end
      else if (vt[i].wr && model.size() < DEPTH) model.push_back(vt[i].b);
      @(negedge clk);
      chk($sformatf("vec%0d_len", i), len, vt[i].len);
      chk($sformatf("vec%0d_full", i), full, vt[i].full);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
    end
    clr = 1'b0; start = 1'b0; wr_dv = 1'b0;

    // "HI" one-shot scroll with busy window
    s = cyc; start = 1'b1; push_scroll(s);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      chk($sformatf("hi_busy_c%0d", i), busy, (i >= 1 && i <= 12) ? 1 : 0);
    end

    // Writes and clears during SCROLL are ignored
    s = cyc; start = 1'b1; push_scroll(s);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      wr_dv = (i <= 6); clr = (i <= 6); wr_byte = "Z";
    end
    wr_dv = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("scroll_ignore_len", len, 2);

    // Looping "AB" then stop on an advance cycle
    clr = 1'b1; model.delete();
    @(negedge clk);
    clr = 1'b0;
    write_str("AB");
    loop_en = 1'b1;
    s = cyc; start = 1'b1;
    push_frame(s + 1, 0); push_frame(s + 5, 1); push_frame(s + 9, 2);
    push_frame(s + 13, 0); push_blank(s + 17);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      chk($sformatf("loop_busy_c%0d", i), busy, (i <= 16) ? 1 : 0);
      if (i == 16) stop = 1'b1;
      if (i == 17) stop = 1'b0;
    end
    loop_en = 1'b0;
    chk("stop_left", ch_l, 8'h20);
    chk("stop_right", ch_r, 8'h20);
    repeat (6) @(negedge clk);
    chk("stop_dv_drained", sbq.size(), 0);

    // Overflow: DEPTH+2 writes, only DEPTH kept
    clr = 1'b1; model.delete();
    @(negedge clk);
    clr = 1'b0;
    write_str("ABCDEF");
    chk("ovf_len", len, DEPTH);
    chk("ovf_full", full, 1);
    s = cyc; start = 1'b1; push_scroll(s);
    for (int i = 1; i <= 23; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("ovf_len_after", len, DEPTH);
    chk("ovf_busy_after", busy, 0);

    // Reset mid-scroll
    s = cyc; start = 1'b1; push_frame(s + 1, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mrst_left", ch_l, 8'h20);
    chk("mrst_right", ch_r, 8'h20);
    chk("mrst_busy", busy, 0);
    chk("mrst_len", len, 0);
    chk("mrst_full", full, 0);
    chk("mrst_dv", ch_dv, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mrst_busy_later", busy, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_text_scroller.md
Name: seg_text_scroller

Overview:
Character source for the two-digit 7-segment display path. A host writes an ASCII message into an internal buffer. On command, the block scrolls that message right-to-left across two character slots at a fixed step rate. It drives two 8-bit ASCII character codes, one per digit, into the downstream character-to-segment encoders.

Parameters:
MSG_DEPTH, 16, message buffer capacity in characters (2..64)
STEP_CYCLES, 12500000, clock cycles per scroll step (0.5 s at 25 MHz); minimum 2

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  asynchronous, active-high reset
i_Wr_DV  input  1  write strobe; one character per cycle while high
i_Wr_Byte  input  8  ASCII character to append
i_Clear  input  1  empty the buffer (IDLE only)
i_Start  input  1  begin scrolling (IDLE only)
i_Stop  input  1  abort scrolling
i_Loop  input  1  1 = restart at frame 0 after the last frame; sampled at each wrap
o_Char_Left  output  8  ASCII code for left digit
o_Char_Right  output  8  ASCII code for right digit
o_Char_DV  output  1  one-cycle pulse when the character outputs change frame
o_Busy  output  1  high in SCROLL
o_Full  output  1  high when length == MSG_DEPTH
o_Len  output  $clog2(MSG_DEPTH+1)  current message length

Behaviour:
- Reset (async, i_Rst=1):
  - state IDLE, length 0.
  - o_Char_Left = o_Char_Right = 8'h20 (blank).
  - o_Char_DV, o_Busy and o_Full all 0.
  - Timer and frame index 0.
  - Buffer contents are not reset.
- States: IDLE, SCROLL.
- IDLE, priority order (highest first):
  - i_Clear: length <= 0. Any write or start in the same cycle is dropped.
  - i_Start with length > 0: enter SCROLL next cycle. A same-cycle write is dropped. i_Start with length 0 is ignored.
  - i_Wr_DV with length < MSG_DEPTH: buffer[length] <= i_Wr_Byte, length++.
  - i_Wr_DV with length == MSG_DEPTH: write dropped; length and buffer unchanged.
- SCROLL:
  - i_Wr_DV, i_Clear and i_Start are ignored.
  - The buffer is frozen for the duration of SCROLL.
- Frames, for k = 0..length (length+1 frames, with len = length):
  - left = (k==0) ? 8'h20 : buffer[k-1]
  - right = (k<len) ? buffer[k] : 8'h20
  - This scrolls the text in from the right and out to the left.
- Timing:
  - The cycle after i_Start is accepted, outputs show frame 0 and o_Char_DV pulses.
  - Each subsequent frame appears exactly STEP_CYCLES cycles after the previous one, with a DV pulse.
  - Frame k is therefore presented at cycle start+1+k*STEP_CYCLES.
- After the last frame (k = length) has been held STEP_CYCLES:
  - i_Loop=1: frame 0 is presented next, with DV.
  - i_Loop=0: return to IDLE; outputs go to 8'h20/8'h20 with one DV pulse; o_Busy falls the same cycle.
- i_Stop in SCROLL: next cycle IDLE, outputs blank, one DV pulse, timer and frame cleared. i_Stop wins over a same-cycle frame advance. i_Stop in IDLE has no effect.
- o_Char_DV never pulses without the outputs being updated in the same cycle. Outputs are registered and hold between pulses.
- o_Full and o_Len are registered and update the cycle after the write or clear.
- Length 1 message: frames (20h,'X'), ('X',20h); 2 frames.
- Reset asserted mid-scroll: immediate return to reset values with no DV pulse.

Test Plan:
- Reset, then write "HI", then i_Start with STEP_CYCLES=4, i_Loop=0:
  - DV at start+1, +5, +9, then +13 (blank).
  - Frames (20h,'H'), ('H','I'), ('I',20h), then 20h/20h.
  - o_Busy high from start+1 through start+12.
- Write MSG_DEPTH+2 bytes 'A'..:
  - o_Len saturates at MSG_DEPTH, o_Full=1.
  - The last two bytes are dropped; a subsequent scroll shows only the first MSG_DEPTH characters.
- i_Loop=1, "AB", STEP_CYCLES=4:
  - After frame 2 ('B',20h), frame 0 (20h,'A') reappears 4 cycles later.
  - No IDLE visit; o_Busy stays 1.
- i_Stop asserted on the same cycle a frame advance is due:
  - Next cycle o_Busy=0, outputs 20h/20h, exactly one DV pulse.
- i_Start with length 0 -> no state change, no DV. i_Clear and i_Wr_DV in the same cycle -> o_Len=0.
- Writes and i_Clear issued during SCROLL -> ignored (o_Len unchanged, scroll content unchanged). i_Rst pulsed mid-scroll -> immediate blank outputs, o_Busy=0, o_Len=0, no DV.
